// File: rtl/uart_frame_receiver_pkg.sv
// Shared framing definitions for the ADC sample link: header bytes, payload limit,
// address width and receiver state encoding, used by both sender and receiver framing.
package uart_frame_receiver_pkg;

    localparam int unsigned ADDR_W          = 10;
    localparam int unsigned DEF_DATA_NUM    = 405;
    localparam logic [7:0]  DEF_HDR0        = 8'hA5;
    localparam logic [7:0]  DEF_HDR1        = 8'h5A;
    localparam logic [19:0] DEF_TIMEOUT_CYC = 20'd500000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_LENH,
        S_LENL,
        S_DATA,
        S_DROP,
        S_CSUM,
        S_DONE
    } state_t;

    // Running frame checksum: plain 8-bit sum of payload bytes, wrapping mod 256.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_frame_receiver_ram.sv
// sample_ram_sp: payload store for one frame; one write port from the parser,
// one registered read port for the display side (1-cycle latency, 0 out of range).
module sample_ram_sp #(
    parameter int unsigned DEPTH = 405,
    parameter int unsigned AW    = 10
) (
    input  logic          in_clk,
    input  logic          in_rst,
    input  logic          in_we,
    input  logic [AW-1:0] in_wr_addr,
    input  logic [7:0]    in_wr_data,
    input  logic [AW-1:0] in_rd_addr,
    output logic [7:0]    out_rd_data
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset branch, so it maps onto block RAM; contents
    // after reset are undefined and only the read register is cleared.
    always_ff @(posedge in_clk) begin
        if (in_we && (in_wr_addr < AW'(DEPTH))) begin
            mem[in_wr_addr[IW-1:0]] <= in_wr_data;
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            out_rd_data <= 8'h00;
        end else if (in_rd_addr < AW'(DEPTH)) begin
            out_rd_data <= mem[in_rd_addr[IW-1:0]];
        end else begin
            out_rd_data <= 8'h00;
        end
    end

endmodule

// File: rtl/uart_frame_receiver.sv
// Parses the UART byte stream into sample frames (header, length, payload) and
// holds one complete frame for the display side. Optional checksum byte: CHECKSUM_EN.
module uart_frame_receiver
    import uart_frame_receiver_pkg::*;
#(
    parameter int unsigned DATA_NUM    = uart_frame_receiver_pkg::DEF_DATA_NUM,
    parameter logic [7:0]  HDR0        = uart_frame_receiver_pkg::DEF_HDR0,
    parameter logic [7:0]  HDR1        = uart_frame_receiver_pkg::DEF_HDR1,
    parameter logic [19:0] TIMEOUT_CYC = uart_frame_receiver_pkg::DEF_TIMEOUT_CYC
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [7:0]        in_rx_data,
    input  logic              in_rx_valid,
    input  logic [ADDR_W-1:0] in_rd_addr,
    output logic [7:0]        out_rd_data,
    output logic              out_frame_valid,
    output logic [ADDR_W-1:0] out_frame_len,
    input  logic              in_frame_ack,
    output logic              out_err,
    output logic              out_busy
);

    localparam logic [ADDR_W-1:0] MAX_LEN = ADDR_W'(DATA_NUM);
`ifdef CHECKSUM_EN
    localparam logic [ADDR_W-1:0] CSUM_BYTES = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] CSUM_BYTES = ADDR_W'(0);
`endif

    state_t            state, state_nx;
    logic [ADDR_W-1:0] len_q, ptr_q, len_full;
    logic [19:0]       tmo_cnt;
    logic              err_nx, ram_we, tmo_hit, byte_ok, valid_eff;
`ifdef CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    assign len_full  = {len_q[9:8], in_rx_data};
    assign tmo_hit   = (state != S_IDLE) && (tmo_cnt >= TIMEOUT_CYC);
    assign byte_ok   = in_rx_valid && !tmo_hit;
    // An ack arriving with the length byte frees the buffer for this very frame.
    assign valid_eff = out_frame_valid && !in_frame_ack;
    assign out_busy  = (state != S_IDLE);

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        ram_we   = 1'b0;
        if (tmo_hit) begin
            state_nx = S_IDLE;
            err_nx   = 1'b1;
        end else if (state == S_DONE) begin
            state_nx = S_IDLE;
        end else if (in_rx_valid) begin
            case (state)
                S_IDLE: if (in_rx_data == HDR0) state_nx = S_HDR1;
                S_HDR1: begin
                    if (in_rx_data == HDR1) begin
                        state_nx = S_LENH;
                    end else if (in_rx_data != HDR0) begin
                        state_nx = S_IDLE;
                        err_nx   = 1'b1;
                    end
                end
                S_LENH: begin
                    if (in_rx_data[7:2] != 6'd0) begin
                        state_nx = S_IDLE;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = S_LENL;
                    end
                end
                S_LENL: begin
                    if ((len_full == '0) || (len_full > MAX_LEN)) begin
                        state_nx = S_IDLE;
                        err_nx   = 1'b1;
                    end else if (valid_eff) begin
                        state_nx = S_DROP;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
                S_DATA: begin
                    ram_we = !out_frame_valid;
`ifdef CHECKSUM_EN
                    if (ptr_q == len_q - 10'd1) state_nx = S_CSUM;
`else
                    if (ptr_q == len_q - 10'd1) state_nx = S_DONE;
`endif
                end
                S_DROP: if (ptr_q == len_q + CSUM_BYTES - 10'd1) state_nx = S_IDLE;
`ifdef CHECKSUM_EN
                S_CSUM: begin
                    if (in_rx_data == sum_q) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_IDLE;
                        err_nx   = 1'b1;
                    end
                end
`endif
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state           <= S_IDLE;
            len_q           <= '0;
            ptr_q           <= '0;
            tmo_cnt         <= '0;
            out_frame_valid <= 1'b0;
            out_frame_len   <= '0;
            out_err         <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q           <= 8'h00;
`endif
        end else begin
            state   <= state_nx;
            out_err <= err_nx;

            if (in_rx_valid)                tmo_cnt <= '0;
            else if (tmo_cnt < TIMEOUT_CYC) tmo_cnt <= tmo_cnt + 20'd1;

            if (byte_ok) begin
                case (state)
                    S_LENH: len_q[9:8] <= in_rx_data[1:0];
                    S_LENL: begin
                        len_q <= len_full;
                        ptr_q <= '0;
`ifdef CHECKSUM_EN
                        sum_q <= 8'h00;
`endif
                    end
                    S_DATA: begin
                        ptr_q <= ptr_q + 10'd1;
`ifdef CHECKSUM_EN
                        sum_q <= csum_add(sum_q, in_rx_data);
`endif
                    end
                    S_DROP:  ptr_q <= ptr_q + 10'd1;
                    default: ;
                endcase
            end

            if (state == S_DONE) begin
                out_frame_valid <= 1'b1;
                out_frame_len   <= len_q;
            end else if (in_frame_ack) begin
                out_frame_valid <= 1'b0;
            end
        end
    end

    sample_ram_sp #(
        .DEPTH (DATA_NUM),
        .AW    (ADDR_W)
    ) u_ram (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_we       (ram_we),
        .in_wr_addr  (ptr_q),
        .in_wr_data  (in_rx_data),
        .in_rd_addr  (in_rd_addr),
        .out_rd_data (out_rd_data)
    );

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Self-checking bench for uart_frame_receiver: directed frames plus randomized frames
// scored against a frame-level model (held buffer image, error count, lengths).
module tb_uart_frame_receiver;
    import uart_frame_receiver_pkg::*;

    localparam int          DN  = 405;
    localparam logic [19:0] TMO = 20'd300;

    typedef logic [7:0] bq_t[$];

    localparam int K_GOOD     = 0;
    localparam int K_BAD_HDR1 = 1;
    localparam int K_BAD_LENH = 2;
    localparam int K_BAD_LEN  = 3;
    localparam int K_BAD_CSUM = 4;
    localparam int K_TIMEOUT  = 5;

    logic       in_clk = 1'b0;
    logic       in_rst = 1'b0;
    logic [7:0] in_rx_data = 8'h00;
    logic       in_rx_valid = 1'b0;
    logic [9:0] in_rd_addr = '0;
    logic [7:0] out_rd_data;
    logic       out_frame_valid;
    logic [9:0] out_frame_len;
    logic       in_frame_ack = 1'b0;
    logic       out_err;
    logic       out_busy;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   err_cnt = 0;
    bit   exp_valid = 1'b0;
    int   exp_len = 0;
    bq_t  exp_mem;

    uart_frame_receiver #(
        .DATA_NUM    (DN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_rx_data      (in_rx_data),
        .in_rx_valid     (in_rx_valid),
        .in_rd_addr      (in_rd_addr),
        .out_rd_data     (out_rd_data),
        .out_frame_valid (out_frame_valid),
        .out_frame_len   (out_frame_len),
        .in_frame_ack    (in_frame_ack),
        .out_err         (out_err),
        .out_busy        (out_busy)
    );

    always #5 in_clk = ~in_clk;

    always @(negedge in_clk) if (out_err === 1'b1) err_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [9:0] a, output logic [7:0] d);
        in_rd_addr = a;
        @(negedge in_clk);
        d = out_rd_data;
    endtask

    task automatic ack();
        in_frame_ack = 1'b1;
        @(negedge in_clk);
        in_frame_ack = 1'b0;
        check("ack_clear", {31'd0, out_frame_valid}, 32'd0);
        exp_valid = 1'b0;
    endtask

    task automatic check_held();
        logic [7:0] d;
        int a;
        check("held_valid", {31'd0, out_frame_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check("held_len", {22'd0, out_frame_len}, exp_len);
            rd(10'd0, d);
            check("ram_first", {24'd0, d}, {24'd0, exp_mem[0]});
            rd(10'(exp_len - 1), d);
            check("ram_last", {24'd0, d}, {24'd0, exp_mem[exp_len-1]});
            a = $urandom_range(0, exp_len - 1);
            rd(10'(a), d);
            check("ram_rand", {24'd0, d}, {24'd0, exp_mem[a]});
        end
    endtask

    task automatic send_raw(input bq_t s, input int exp_err);
        int e0;
        e0 = err_cnt;
        foreach (s[i]) begin
            in_rx_data  = s[i];
            in_rx_valid = 1'b1;
            @(negedge in_clk);
            in_rx_valid = 1'b0;
            @(negedge in_clk);
        end
        repeat (4) @(negedge in_clk);
        check("raw_err", err_cnt - e0, exp_err);
        check("raw_busy", {31'd0, out_busy}, 32'd0);
    endtask

    task automatic run_frame(input bq_t pl, input int kind, input bit ack_lenl);
        bq_t        s;
        logic [7:0] cs, b;
        logic [9:0] l;
        int         n, e0, exp_err, keep;
        bit         held, accept;
        n  = pl.size();
        cs = 8'h00;
        foreach (pl[i]) cs = cs + pl[i];
        s.delete();
        s.push_back(DEF_HDR0);
        case (kind)
            K_BAD_HDR1: begin
                b = 8'h00;
                do b = 8'($urandom); while (b == DEF_HDR0 || b == DEF_HDR1);
                s.push_back(b);
            end
            K_BAD_LENH: begin
                s.push_back(DEF_HDR1);
                s.push_back(8'($urandom_range(4, 255)));
            end
            K_BAD_LEN: begin
                l = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(DN + 1, 1023));
                s.push_back(DEF_HDR1);
                s.push_back({6'd0, l[9:8]});
                s.push_back(l[7:0]);
            end
            default: begin
                l = 10'(n);
                s.push_back(DEF_HDR1);
                s.push_back({6'd0, l[9:8]});
                s.push_back(l[7:0]);
                keep = (kind == K_TIMEOUT) ? n / 2 : n;
                for (int i = 0; i < keep; i++) s.push_back(pl[i]);
`ifdef CHECKSUM_EN
                if (kind == K_GOOD)     s.push_back(cs);
                if (kind == K_BAD_CSUM) s.push_back(cs ^ 8'($urandom_range(1, 255)));
`endif
            end
        endcase

        held    = exp_valid && !(ack_lenl && s.size() > 3);
        accept  = (kind == K_GOOD) && !held;
        exp_err = (kind == K_GOOD || (kind == K_BAD_CSUM && held)) ? 0 : 1;
        e0      = err_cnt;

        for (int i = 0; i < s.size(); i++) begin
            in_rx_data   = s[i];
            in_rx_valid  = 1'b1;
            in_frame_ack = ack_lenl && (i == 3);
            @(negedge in_clk);
            in_rx_valid  = 1'b0;
            in_frame_ack = 1'b0;
            if (i != s.size() - 1) repeat ($urandom_range(0, 2)) @(negedge in_clk);
        end
        if (ack_lenl && s.size() > 3) exp_valid = 1'b0;

        if (kind == K_TIMEOUT) repeat (int'(TMO) + 10) @(negedge in_clk);
        if (accept) begin
            check("done_lat1", {31'd0, out_frame_valid}, 32'd0);
            @(negedge in_clk);
            check("done_lat2", {31'd0, out_frame_valid}, 32'd1);
            exp_valid = 1'b1;
            exp_len   = n;
            exp_mem   = pl;
        end
        repeat (4) @(negedge in_clk);
        check("frame_err", err_cnt - e0, exp_err);
        check("frame_busy", {31'd0, out_busy}, 32'd0);
        check_held();
    endtask

    initial begin
        bq_t        pl, raw;
        logic [7:0] d;
        int         kind, n;

        // Reset state
        repeat (3) @(negedge in_clk);
        check("rst_valid", {31'd0, out_frame_valid}, 32'd0);
        check("rst_len", {22'd0, out_frame_len}, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        check("rst_busy", {31'd0, out_busy}, 32'd0);
        check("rst_rd", {24'd0, out_rd_data}, 32'd0);
        in_rst = 1'b1;
        @(negedge in_clk);

        // Short frame of four bytes
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(pl, K_GOOD, 1'b0);
        check("t1_len", {22'd0, out_frame_len}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            rd(10'(i), d);
            check("t1_data", {24'd0, d}, {24'd0, pl[i]});
        end
        ack();

        // Full-length ramp
        pl.delete();
        for (int i = 0; i < DN; i++) pl.push_back(8'(i));
`ifdef CHECKSUM_EN
        run_frame(pl, K_BAD_CSUM, 1'b0);
`endif
        run_frame(pl, K_GOOD, 1'b0);
        rd(10'd404, d);
        check("t2_addr404", {24'd0, d}, 32'h94);
        check("t2_len", {22'd0, out_frame_len}, 32'd405);
        ack();

        // Leading noise and repeated first header byte
        raw = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h01, 8'h7E};
`ifdef CHECKSUM_EN
        raw.push_back(8'h7E);
`endif
        send_raw(raw, 0);
        check("t3_valid", {31'd0, out_frame_valid}, 32'd1);
        check("t3_len", {22'd0, out_frame_len}, 32'd1);
        rd(10'd0, d);
        check("t3_data", {24'd0, d}, 32'h7E);
        in_frame_ack = 1'b1;
        @(negedge in_clk);
        in_frame_ack = 1'b0;
        exp_valid = 1'b0;

        // Illegal lengths, then recovery
        send_raw('{8'hA5, 8'h5A, 8'h00, 8'h00}, 1);
        send_raw('{8'hA5, 8'h5A, 8'h01, 8'h96}, 1);
        run_frame('{8'hC1, 8'hC2, 8'hC3}, K_GOOD, 1'b0);

        // Drop while held, ack then accept, ack coincident with length byte
        run_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, K_GOOD, 1'b0);
        ack();
        run_frame('{8'hD0, 8'hD1}, K_GOOD, 1'b0);
        run_frame('{8'hE0, 8'hE1, 8'hE2}, K_GOOD, 1'b1);
        ack();

        // Inter-byte timeout, then reset mid-frame
        run_frame('{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60}, K_TIMEOUT, 1'b0);
        foreach (raw[i]) raw.delete(i);
        raw = '{8'hA5, 8'h5A, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03};
        foreach (raw[i]) begin
            in_rx_data  = raw[i];
            in_rx_valid = 1'b1;
            @(negedge in_clk);
            in_rx_valid = 1'b0;
        end
        in_rst = 1'b0;
        @(negedge in_clk);
        @(negedge in_clk);
        check("mid_rst_valid", {31'd0, out_frame_valid}, 32'd0);
        check("mid_rst_len", {22'd0, out_frame_len}, 32'd0);
        check("mid_rst_err", {31'd0, out_err}, 32'd0);
        check("mid_rst_busy", {31'd0, out_busy}, 32'd0);
        check("mid_rst_rd", {24'd0, out_rd_data}, 32'd0);
        in_rst = 1'b1;
        exp_valid = 1'b0;
        @(negedge in_clk);
        run_frame('{8'h5C, 8'h6D}, K_GOOD, 1'b0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            if (exp_valid && $urandom_range(0, 1) == 1) ack();
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, DN) : $urandom_range(1, 24);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            kind = $urandom_range(0, 9);
            if (kind > K_TIMEOUT) kind = K_GOOD;
`ifndef CHECKSUM_EN
            if (kind == K_BAD_CSUM) kind = K_GOOD;
`endif
            run_frame(pl, kind, 1'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
